// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture lock latch.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gesture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int FRAME_W_DEF = 8;
    localparam int NCLASS_DEF  = 3;

    // Bit positions of each gesture inside the one-hot class field.
    localparam int ROCK     = 2;
    localparam int PAPER    = 1;
    localparam int SCISSORS = 0;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/gesture_lock_latch_rise_detect.sv
// Rising-edge detector: one-cycle pulse when d goes from 0 to 1.
// Latency: combinational pulse in the same cycle d is first seen high.
// Backpressure: none; a level held high yields a single pulse.
module rise_detect
    import gesture_pkg::*;
#(
    parameter logic PRESET = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Registered copy of d; preset on reset so a level already high is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) d_q <= PRESET;
        else       d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/gesture_lock_latch.sv
// Qualifies one-hot gesture frames and latches the gesture after STABLE_CNT agreeing frames.
// Latency: led/valid update on the same edge that samples done rising.
// Backpressure: none; frames outside ACQUIRE or colliding with clear are dropped.
module gesture_lock_latch
    import gesture_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int NCLASS     = NCLASS_DEF,
    parameter int STABLE_CNT = 2,
    parameter int CNT_W      = 4
) (
    input  logic               sck,
    input  logic               reset,
    input  logic               start,
    input  logic               done,
    input  logic [FRAME_W-1:0] sig,
    input  logic               clear,
    output logic [NCLASS-1:0]  led,
    output logic               valid,
    output logic [CNT_W-1:0]   invalid_cnt
);

    localparam int AW = $clog2(STABLE_CNT + 1);

    state_t            state, state_nxt;
    logic [NCLASS-1:0] cand, cand_nxt;
    logic [AW-1:0]     agree, agree_nxt, agree_upd;
    logic [NCLASS-1:0] led_nxt;
    logic              valid_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              fs;
    logic [NCLASS-1:0] f;
    logic              f_ok;

    // Payload bits below the class field carry nothing this block uses.
    logic unused_payload;
    assign unused_payload = ^sig[FRAME_W-NCLASS-1:0];

    assign f    = sig[FRAME_W-1 -: NCLASS];
    assign f_ok = is_onehot(32'(f));

    rise_detect #(.PRESET(1'b1)) u_done_rise (
        .clk   (sck),
        .reset (reset),
        .d     (done),
        .pulse (fs)
    );

    // State and datapath registers.
    always_ff @(posedge sck) begin
        if (reset) begin
            state       <= IDLE;
            led         <= '0;
            valid       <= 1'b0;
            invalid_cnt <= '0;
            cand        <= '0;
            agree       <= '0;
        end else begin
            state       <= state_nxt;
            led         <= led_nxt;
            valid       <= valid_nxt;
            invalid_cnt <= cnt_nxt;
            cand        <= cand_nxt;
            agree       <= agree_nxt;
        end
    end

    // Next-state logic: start low overrides everything, then clear, then the frame strobe.
    always_comb begin
        state_nxt = state;
        led_nxt   = led;
        valid_nxt = valid;
        cnt_nxt   = invalid_cnt;
        cand_nxt  = cand;
        agree_nxt = agree;
        agree_upd = agree;
        if (!start) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ACQUIRE;
                    led_nxt   = '0;
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    cand_nxt  = '0;
                    agree_nxt = '0;
                end
                ACQUIRE: begin
                    if (clear) begin
                        cand_nxt  = '0;
                        agree_nxt = '0;
                    end else if (fs) begin
                        if (!f_ok) begin
                            agree_nxt = '0;
                            if (invalid_cnt != {CNT_W{1'b1}}) cnt_nxt = invalid_cnt + 1'b1;
                        end else begin
                            // agree stays below STABLE_CNT while acquiring, so +1 cannot wrap.
                            if (f == cand && agree != '0) begin
                                agree_upd = agree + 1'b1;
                            end else begin
                                cand_nxt  = f;
                                agree_upd = AW'(1);
                            end
                            agree_nxt = agree_upd;
                            if (agree_upd == AW'(STABLE_CNT)) begin
                                led_nxt   = f;
                                valid_nxt = 1'b1;
                                state_nxt = LOCKED;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (clear) begin
                        state_nxt = ACQUIRE;
                        led_nxt   = '0;
                        valid_nxt = 1'b0;
                        cand_nxt  = '0;
                        agree_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_lock_latch.sv
// Directed bench for gesture_lock_latch with hand-computed expectations.
// Latency: checks sampled on the falling edge after each stimulus step.
// Backpressure: n/a.
module tb_gesture_lock_latch;

    logic       sck;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] sig;
    logic       clear;
    logic [2:0] led;
    logic       valid;
    logic [3:0] invalid_cnt;

    int errors = 0;
    int checks = 0;

    gesture_lock_latch #(
        .FRAME_W    (8),
        .NCLASS     (3),
        .STABLE_CNT (2),
        .CNT_W      (4)
    ) dut (
        .sck         (sck),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .sig         (sig),
        .clear       (clear),
        .led         (led),
        .valid       (valid),
        .invalid_cnt (invalid_cnt)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_led, input logic e_valid,
                             input logic [3:0] e_cnt);
        check({tag, ".led"},   32'(led),         32'(e_led));
        check({tag, ".valid"}, 32'(valid),       32'(e_valid));
        check({tag, ".cnt"},   32'(invalid_cnt), 32'(e_cnt));
    endtask

    // One frame: done high for one cycle, then low for one cycle.
    task automatic send_frame(input logic [7:0] b);
        @(negedge sck);
        sig  = b;
        done = 1'b1;
        @(negedge sck);
        done = 1'b0;
        @(negedge sck);
    endtask

    task automatic pulse_clear();
        @(negedge sck);
        clear = 1'b1;
        @(negedge sck);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        done  = 1'b1;
        sig   = 8'h00;
        clear = 1'b0;
        repeat (3) @(negedge sck);
        check_out("reset", 3'b000, 1'b0, 4'd0);

        // Test 1: done already high at reset release gives no strobe.
        reset = 1'b0;
        start = 1'b1;
        sig   = 8'h80;
        repeat (3) @(negedge sck);
        check_out("t1_no_strobe", 3'b000, 1'b0, 4'd0);
        done = 1'b0;
        @(negedge sck);

        // Test 2: two agreeing rock frames lock; output appears after the sampling edge.
        send_frame(8'h80);
        check_out("t2_first", 3'b000, 1'b0, 4'd0);
        @(negedge sck);
        sig  = 8'h80;
        done = 1'b1;
        #1;
        check("t2_pre_edge.valid", 32'(valid), 32'd0);
        @(negedge sck);
        check_out("t2_lock", 3'b100, 1'b1, 4'd0);
        done = 1'b0;
        @(negedge sck);

        // Test 5: locked frames ignored, clear releases, relock on paper.
        for (int i = 0; i < 3; i++) send_frame(8'h40);
        check_out("t5_locked_hold", 3'b100, 1'b1, 4'd0);
        pulse_clear();
        check_out("t5_cleared", 3'b000, 1'b0, 4'd0);
        send_frame(8'h40);
        send_frame(8'h40);
        check_out("t5_relock", 3'b010, 1'b1, 4'd0);

        // Test 5b: a strobe coinciding with clear is dropped.
        pulse_clear();
        @(negedge sck);
        clear = 1'b1;
        sig   = 8'h20;
        done  = 1'b1;
        @(negedge sck);
        clear = 1'b0;
        done  = 1'b0;
        @(negedge sck);
        send_frame(8'h20);
        check_out("t5_clear_drop", 3'b000, 1'b0, 4'd0);
        send_frame(8'h20);
        check_out("t5_clear_lock", 3'b001, 1'b1, 4'd0);

        // Test 3: candidate switch restarts agreement.
        pulse_clear();
        send_frame(8'h80);
        send_frame(8'h40);
        check_out("t3_switch", 3'b000, 1'b0, 4'd0);
        send_frame(8'h40);
        check_out("t3_lock", 3'b010, 1'b1, 4'd0);

        // Test 4: multi-hot and zero fields are rejected and counted.
        pulse_clear();
        send_frame(8'hC0);
        send_frame(8'h00);
        check_out("t4_invalid", 3'b000, 1'b0, 4'd2);
        send_frame(8'h20);
        send_frame(8'h20);
        check_out("t4_lock", 3'b001, 1'b1, 4'd2);
        send_frame(8'hC0);
        check_out("t4_cnt_frozen", 3'b001, 1'b1, 4'd2);

        // Test 6: dropping start resets agreement; count and display persist while idle.
        pulse_clear();
        send_frame(8'h80);
        @(negedge sck);
        start = 1'b0;
        @(negedge sck);
        check_out("t6_idle", 3'b000, 1'b0, 4'd2);
        start = 1'b1;
        @(negedge sck);
        check_out("t6_rearm", 3'b000, 1'b0, 4'd0);
        send_frame(8'h80);
        check_out("t6_single", 3'b000, 1'b0, 4'd0);
        send_frame(8'h80);
        check_out("t6_lock", 3'b100, 1'b1, 4'd0);

        // Display retained through IDLE; frames ignored there.
        @(negedge sck);
        start = 1'b0;
        send_frame(8'h40);
        send_frame(8'h40);
        check_out("idle_retain", 3'b100, 1'b1, 4'd0);
        start = 1'b1;
        @(negedge sck);
        check_out("idle_rearm", 3'b000, 1'b0, 4'd0);

        // done held high for several cycles is a single strobe.
        @(negedge sck);
        sig  = 8'h80;
        done = 1'b1;
        repeat (5) @(negedge sck);
        check_out("done_held", 3'b000, 1'b0, 4'd0);
        done = 1'b0;
        @(negedge sck);
        send_frame(8'h80);
        check_out("done_held_lock", 3'b100, 1'b1, 4'd0);

        // Saturation of the invalid counter after 17 rejected frames.
        pulse_clear();
        for (int i = 0; i < 15; i++) send_frame(8'hE0);
        check_out("sat_15", 3'b000, 1'b0, 4'd15);
        send_frame(8'h00);
        send_frame(8'hE0);
        check_out("sat_17", 3'b000, 1'b0, 4'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gesture_lock_latch.md
Name: gesture_lock_latch

Overview:
Parametrised successor to the gesture-to-LED latch. It qualifies gesture frames from the SPI receiver and drives the gesture LEDs. Each frame must carry a one-hot class field. N consecutive agreeing frames are required before the gesture locks. The block counts rejected frames and supports explicit round clear. It sits between the SPI byte receiver and the LED pins, clocked by the SPI-side clock.

Parameters:
FRAME_W, 8, width of received frame
NCLASS, 3, number of gesture classes; class field = sig[FRAME_W-1 -: NCLASS]
STABLE_CNT, 2, consecutive identical valid frames required to lock (>=1)
CNT_W, 4, width of saturating invalid-frame counter

Ports:
sck  in  1  block clock
reset  in  1  synchronous, active-high reset
start  in  1  round armed (level)
done  in  1  frame-complete level from receiver; rising edge = new frame
sig  in  FRAME_W  received frame
clear  in  1  release lock, restart acquisition (level, sampled each cycle)
led  out  NCLASS  locked gesture, one-hot (bit NCLASS-1 = rock, then paper, scissors)
valid  out  1  led holds a locked gesture
invalid_cnt  out  CNT_W  saturating count of rejected frames this round

Behaviour:
- Reset values (sync, active-high): state=IDLE, led=0, valid=0, invalid_cnt=0, cand=0, agree=0.
- Reset sets done_q=1, so a done already high at reset release yields no strobe.
- Frame strobe: fs = done & ~done_q. done_q is a registered copy of done. fs is acted on only in ACQUIRE.
- Field f = sig[FRAME_W-1 -: NCLASS]. f is valid iff exactly one bit is set; 0 or >=2 bits set is invalid.
- Priority per cycle: reset > start==0 > clear > fs.
- IDLE:
  - Frames ignored.
  - start==1 -> ACQUIRE next cycle; on that transition clear led, valid, invalid_cnt, cand, agree.
- ACQUIRE:
  - clear: cand=0, agree=0; led/valid stay 0.
  - fs with invalid f: agree=0; invalid_cnt+1, saturating at 2^CNT_W-1.
  - fs with valid f, f==cand and agree>0: agree+1.
  - fs with valid f otherwise: cand=f, agree=1.
  - If the updated agree equals STABLE_CNT: led=f, valid=1, -> LOCKED, all on that same edge. Output is visible in the cycle after the edge that samples done rising.
  - STABLE_CNT=1: first valid frame locks.
- LOCKED:
  - All frames ignored; invalid_cnt frozen.
  - clear -> ACQUIRE with led=0, valid=0, cand=0, agree=0; invalid_cnt retained.
- start==0 in any state -> IDLE; led, valid, invalid_cnt retain values (display persists between rounds).
- agree width: clog2(STABLE_CNT+1); it never exceeds STABLE_CNT.
- fs and clear in the same cycle: clear wins, frame dropped.
- fs in the same cycle start rises: dropped, since state is still IDLE.
- done held high across many cycles: single strobe.
- led is always 0 or one-hot; never multi-hot.

Decomposition:
- Package gesture_pkg:
  - state enum {IDLE, ACQUIRE, LOCKED}
  - default NCLASS / FRAME_W constants
  - class index constants ROCK=2, PAPER=1, SCISSORS=0
  - pure function is_onehot()
- One sub-module, rise_detect: registered rising-edge pulse with a reset preset value parameter (used with preset=1).

Test Plan:
1. Hold done=1 through reset, release, start=1 -> no strobe: led=000, valid=0, invalid_cnt=0.
2. start=1; frames 0x80, 0x80 -> after first strobe valid=0; after second, led=100, valid=1 on the next cycle.
3. Frames 0x80, 0x40, 0x40 -> no lock on 2nd frame (cand switches); lock led=010 on 3rd.
4. Frames 0xC0, 0x00 -> invalid_cnt=2, valid=0; then 0x20, 0x20 -> led=001, valid=1. Separately, 17 invalid frames -> invalid_cnt=15 (saturated).
5. Locked on 100; frames 0x40 x3 -> led stays 100; clear pulse -> led=000, valid=0; then 0x40, 0x40 -> led=010. Also clear asserted with a strobe -> frame dropped.
6. ACQUIRE after one 0x80 frame, start dropped then raised -> agree reset; a single 0x80 does not lock, a second does.
